uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial-to-parallel UART receiver; the downstream counterpart of the team's UART transmitter.
- Decodes frames of 1 start, 8 data (LSB first), 1 even-parity and 1 stop bit from an asynchronous rx line.
- Presents each byte with a single-cycle valid strobe and per-frame error flags.
- Sits at the board RX pin (or TX loopback) and feeds byte consumers such as a FIFO or command parser.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line bit rate. DIVIDER = CLK_FREQ/BAUD (integer division), HALF = DIVIDER/2. Requires DIVIDER >= 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data  output  8  last received byte; holds value until next completed frame.
- valid  output  1  one-cycle strobe: data/parity_err/frame_err updated this cycle.
- parity_err  output  1  last frame's parity bit mismatched even parity; held like data.
- frame_err  output  1  last frame's stop bit sampled 0; held like data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset, async, active-high. Clears data=0, valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, counters=0. Synchronizer flops reset to 1 (idle line).
- A reset asserted mid-frame aborts the frame with no valid strobe.
- Input sync: rx passes through 2 flops, giving rx_s. All decisions use rx_s. rx_s_d (one more flop) is used for edge detection.
- Bit counter: cnt, width $clog2(DIVIDER). Cleared on each state entry, increments every clk while busy.
- IDLE: on rx_s_d=1 and rx_s=0 (falling edge), go to START with cnt=0.
- START: when cnt==HALF-1, sample rx_s.
  - 0: go to DATA, cnt=0, bit index=0.
  - 1: glitch. Return to IDLE with no output change.
- DATA: when cnt==DIVIDER-1, sample rx_s into shift register bit [index], LSB first, and clear cnt. After index 7, go to PARITY.
- PARITY: when cnt==DIVIDER-1, sample the parity bit. Go to STOP.
- STOP: when cnt==DIVIDER-1, sample the stop bit. On the following clk edge:
  - data <= shift register.
  - parity_err <= (^shift register) ^ parity bit.
  - frame_err <= ~stop bit.
  - valid=1 for exactly that one cycle.
- After STOP:
  - stop=1: go to IDLE.
  - stop=0: go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then IDLE. A break or stuck-low line produces exactly one frame_err frame, not a stream.
- Valid is asserted for every completed frame, including errored ones. Consumers qualify with the error flags. No backpressure; a byte not taken before the next valid is overwritten.
- Samples fall at bit centres: HALF after the detected edge, then every DIVIDER cycles.
- Latency, falling edge of rx to valid: 2 sync cycles + 1 edge cycle + HALF + 10*DIVIDER + 1 cycle, tolerance ±1 cycle.
- Back-to-back frames: a start edge arriving immediately after the stop bit centre must be caught. IDLE is re-entered before the next falling edge is possible.
- Baud error tolerance: ±2 % cumulative clock mismatch must decode correctly.

Test Plan:
- Use CLK_FREQ=50_000_000, BAUD=6_250_000 (DIVIDER=8) for fast sim. Repeat scenario 1 at 115200.
- 1. Drive frame 0xA5, parity 0, stop 1 -> one valid pulse, data=0xA5, parity_err=0, frame_err=0, busy low after frame.
- 2. Send 0x07 with parity 1, then 0x3C with parity 1 (wrong), back-to-back -> valid #1: data=0x07, parity_err=0. Valid #2: data=0x3C, parity_err=1.
- 3. Pulse rx low for 3 clk (< HALF) -> no valid, busy returns to 0 within HALF+3 cycles, data unchanged.
- 4. Send 0x55 with stop=0, hold rx low 40 cycles, then release, then send 0x12 -> exactly one valid with data=0x55, frame_err=1. Next valid: data=0x12, frame_err=0.
- 5. Assert reset during DATA bit 4 of 0xFF -> no valid, outputs at reset values. Next frame 0x81 is received correctly.
- 6. Loopback: connect the team UART transmitter (same params) tx to rx and send 256 bytes 0x00..0xFF -> 256 valid pulses, in-order data, no error flags. Repeat with rx clocked 2 % fast -> same result.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8E1 UART receiver with bit-centre sampling, one-cycle valid strobe and per-frame error flags
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   rx         serial line, idle high, asynchronous to clk
//   data       last received byte, held until the next completed frame
//   valid      one-cycle strobe when data/parity_err/frame_err are updated
//   parity_err last frame failed even parity
//   frame_err  last frame's stop bit sampled low
//   busy       receiver is anywhere but IDLE
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int DIVIDER = CLK_FREQ / BAUD;
    localparam int HALF    = DIVIDER / 2;
    localparam int CW      = $clog2(DIVIDER);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIVIDER - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE} state_t;

    state_t        state;
    logic          rx_m, rx_s, rx_s_d;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sh;
    logic          par_bit, stop_bit;
    logic          bit_end;

    assign bit_end = cnt == DIV_M1;
    assign busy    = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            rx_s_d     <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            par_bit    <= 1'b0;
            stop_bit   <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
            valid  <= 1'b0;
            cnt    <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_s_d && !rx_s) state <= START;
                end
                // a start bit that is high again at its centre was a glitch
                START: if (cnt == HALF_M1) begin
                    cnt   <= '0;
                    idx   <= '0;
                    state <= rx_s ? IDLE : DATA;
                end
                DATA: if (bit_end) begin
                    cnt     <= '0;
                    sh[idx] <= rx_s;
                    idx     <= idx + 1'b1;
                    if (idx == 3'd7) state <= PARITY;
                end
                PARITY: if (bit_end) begin
                    cnt     <= '0;
                    par_bit <= rx_s;
                    state   <= STOP;
                end
                STOP: if (bit_end) begin
                    cnt      <= '0;
                    stop_bit <= rx_s;
                    state    <= DONE;
                end
                DONE: begin
                    cnt        <= '0;
                    data       <= sh;
                    parity_err <= (^sh) ^ par_bit;
                    frame_err  <= ~stop_bit;
                    valid      <= 1'b1;
                    state      <= stop_bit ? IDLE : WAIT_IDLE;
                end
                // a low stop bit may be a break; wait for the line to recover so it reports once
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at DIVIDER=8 and at 115200 baud
`timescale 1ns/1ps
module tb_uart_rx;
    logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, rx2 = 1'b1;
    logic [7:0] data, data2;
    logic       valid, valid2, perr, perr2, ferr, ferr2, busy, busy2;
    int         checks = 0, failures = 0;
    realtime    t_fall, t_valid, lat;

    typedef struct packed {logic [7:0] d; logic p; logic f;} exp_t;
    exp_t q[$], q2[$];

    always #5 clk = ~clk;

    uart_rx #(.CLK_FREQ(50_000_000), .BAUD(6_250_000)) dut (
        .clk(clk), .reset(reset), .rx(rx), .data(data), .valid(valid),
        .parity_err(perr), .frame_err(ferr), .busy(busy));

    uart_rx #(.CLK_FREQ(50_000_000), .BAUD(115200)) dut2 (
        .clk(clk), .reset(reset), .rx(rx2), .data(data2), .valid(valid2),
        .parity_err(perr2), .frame_err(ferr2), .busy(busy2));

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic void push(bit sel, logic [7:0] b, logic p, logic f);
        if (sel) q2.push_back(exp_t'({b, p, f}));
        else q.push_back(exp_t'({b, p, f}));
    endfunction

    task automatic send(input bit sel, input logic [7:0] b, input logic p, input logic s, input real bt);
        logic [10:0] f;
        f = {s, p, b, 1'b0};
        if (!sel) t_fall = $realtime;
        for (int i = 0; i < 11; i++) begin
            if (sel) rx2 = f[i];
            else rx = f[i];
            #(bt);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10000 && (q.size() != 0 || q2.size() != 0); i++) @(posedge clk);
        chk("pending_fast", q.size(), 0);
        chk("pending_slow", q2.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid) begin
            t_valid = $realtime;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got data %0h expected no strobe", data);
            end else begin
                e = q.pop_front();
                chk("data", data, e.d);
                chk("parity_err", perr, e.p);
                chk("frame_err", ferr, e.f);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid2) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid2: got data %0h expected no strobe", data2);
            end else begin
                e = q2.pop_front();
                chk("data2", data2, e.d);
                chk("parity_err2", perr2, e.p);
                chk("frame_err2", ferr2, e.f);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        // 1: single frame, latency and busy
        push(0, 8'hA5, 0, 0);
        send(0, 8'hA5, 1'b0, 1'b1, 80.0);
        drain();
        lat = t_valid - t_fall;
        checks++;
        if (lat < 874.0 || lat > 894.0) begin
            failures++;
            $display("FAIL latency: got %0t expected 884ns +-10ns", lat);
        end
        repeat (3) @(posedge clk);
        #1 chk("busy_after_frame", busy, 0);
        // 1 again at 115200
        push(1, 8'hA5, 0, 0);
        send(1, 8'hA5, 1'b0, 1'b1, 4340.0);
        drain();
        repeat (3) @(posedge clk);
        #1 chk("busy2_after_frame", busy2, 0);
        // 2: back-to-back, second with bad parity
        @(posedge clk);
        #1;
        push(0, 8'h07, 0, 0);
        push(0, 8'h3C, 1, 0);
        send(0, 8'h07, 1'b1, 1'b1, 80.0);
        send(0, 8'h3C, 1'b1, 1'b1, 80.0);
        drain();
        // 3: short glitch
        @(posedge clk);
        #1 rx = 1'b0;
        #30 rx = 1'b1;
        #5 chk("busy_on_glitch", busy, 1);
        repeat (10) @(posedge clk);
        #1 chk("busy_after_glitch", busy, 0);
        chk("data_after_glitch", data, 8'h3C);
        // 4: stop bit low followed by a held-low line
        @(posedge clk);
        #1;
        push(0, 8'h55, 0, 1);
        send(0, 8'h55, 1'b0, 1'b0, 80.0);
        #400 chk("busy_wait_idle", busy, 1);
        rx = 1'b1;
        #200;
        push(0, 8'h12, 0, 0);
        send(0, 8'h12, 1'b0, 1'b1, 80.0);
        drain();
        // 5: reset during data bit 4 of 0xFF
        @(posedge clk);
        #1 rx = 1'b0;
        #80 rx = 1'b1;
        #360 reset = 1'b1;
        #12;
        chk("midrst_data", data, 8'h00);
        chk("midrst_valid", valid, 0);
        chk("midrst_perr", perr, 0);
        chk("midrst_ferr", ferr, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        push(0, 8'h81, 0, 0);
        send(0, 8'h81, 1'b0, 1'b1, 80.0);
        drain();
        // 6: stream of all bytes, nominal and with a 2% slow line
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) begin
            push(0, 8'(i), 0, 0);
            send(0, 8'(i), ^(8'(i)), 1'b1, 80.0);
        end
        drain();
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) begin
            push(0, 8'(i), 0, 0);
            send(0, 8'(i), ^(8'(i)), 1'b1, 81.6);
        end
        drain();
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
